// File: rtl/sample3_sweep_ctrl.sv
// Stimulus sequencer and response capture for the sample3 function block.
// On start, every input vector 0..2**N_IN-1 is driven onto a/b/c/d and held
// for HOLD_CYCLES clocks. f_in is captured at the end of each hold into
// table_out. The captured table is then compared against expected_tt.
module sample3_sweep_ctrl #(
  parameter int N_IN        = 4,
  parameter int HOLD_CYCLES = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   f_in,
  input  logic [(1<<N_IN)-1:0]   expected_tt,
  output logic                   a,
  output logic                   b,
  output logic                   c,
  output logic                   d,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   table_out,
  output logic                   mismatch
);

  localparam int NVEC = 1 << N_IN;
  localparam int HW   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    FINISH
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [N_IN-1:0]   idx;
  logic [HW-1:0]     hold_cnt;
  logic              launch;
  logic              hold_end;
  logic              last_vec;
  logic [NVEC-1:0]   table_sampled;

  // Abort beats start in IDLE and beats the final sample of a hold in DRIVE.
  assign launch   = (state == IDLE) && start && !abort;
  assign hold_end = (state == DRIVE) && !abort && (hold_cnt == HW'(HOLD_CYCLES - 1));
  assign last_vec = (idx == N_IN'(NVEC - 1));

  // The vector index is itself a register, so the stimulus pins are glitch-free.
  assign {a, b, c, d} = idx;

  // Table with the current response merged in at the current index.
  always_comb begin
    table_sampled      = table_out;
    table_sampled[idx] = f_in;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and status decode.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (launch) begin
          state_next = DRIVE;
        end
      end
      DRIVE: begin
        busy = 1'b1;
        if (abort) begin
          state_next = IDLE;
        end else if (hold_end && last_vec) begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Vector stepping, hold counting, response capture and the final compare.
  // mismatch is formed from the just-completed table when entering FINISH so
  // it is already valid in the done cycle, and refreshed once more in FINISH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      hold_cnt  <= '0;
      table_out <= '0;
      mismatch  <= 1'b0;
    end else if (launch) begin
      idx       <= '0;
      hold_cnt  <= '0;
      table_out <= '0;
      mismatch  <= 1'b0;
    end else if (state == DRIVE) begin
      if (abort) begin
        hold_cnt <= '0;
      end else if (hold_end) begin
        table_out <= table_sampled;
        hold_cnt  <= '0;
        if (last_vec) begin
          mismatch <= (table_sampled != expected_tt);
        end else begin
          idx <= idx + 1'b1;
        end
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end else if (state == FINISH) begin
      mismatch <= (table_out != expected_tt);
    end
  end

endmodule
